seq_controller: RTL and testbench

- Step sequencer controller for the synth playback path.
- Consumes the level-type play/pause flag from the play/pause toggle FSM and a stop button.
- Advances a step index at a fixed tempo and drives a per-step gate for the tone generator.
- Downstream note lookup and tone blocks read step and gate; this block is the only owner of playback timing.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_if.sv | 44 ++++
 rtl/seq_tick_timer.sv | 42 ++++
 rtl/seq_controller.sv | 196 +++++++++++++++++++
 tb/tb_seq_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the step sequencer slice.
//   - seq_state_t : FSM state encoding (3 bits)
//   - PHASE_*     : encoding of the 1-bit register that remembers which
//                   running state a pause interrupted
//   - DEF_*       : default pattern size and tempo for a 50 MHz clock
//                   (4 steps per second, 75 % gate)
// Optional feature macro used by the controller: SEQ_LOOP_EN.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_GATE = 3'd1,
        RUN_REST = 3'd2,
        PAUSED   = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

    localparam logic PHASE_GATE = 1'b0;
    localparam logic PHASE_REST = 1'b1;

    localparam int DEF_NUM_STEPS      = 16;
    localparam int DEF_STEP_W         = 4;
    localparam int DEF_CNT_W          = 24;
    localparam int DEF_TICKS_PER_STEP = 12500000;
    localparam int DEF_GATE_TICKS     = 9375000;

endpackage

// File: rtl/seq_if.sv
// seq_if: control and playback signals of the step sequencer.
//   play        : level, 1 = play, 0 = pause (synchronous to clk)
//   stop_n      : stop button, active-low, already synchronised
//   step        : current step index
//   gate        : note-on gate for the current step
//   step_strobe : one-cycle pulse on the first cycle of each step
//   running     : sequencer is actively playing
//   done        : one-shot pattern has finished
// Modports:
//   master : the side issuing play/stop and observing playback
//   slave  : the sequencer controller itself
interface seq_if #(
    parameter int STEP_W = 4
);

    logic              play;
    logic              stop_n;
    logic [STEP_W-1:0] step;
    logic              gate;
    logic              step_strobe;
    logic              running;
    logic              done;

    modport master (
        output play,
        output stop_n,
        input  step,
        input  gate,
        input  step_strobe,
        input  running,
        input  done
    );

    modport slave (
        input  play,
        input  stop_n,
        output step,
        output gate,
        output step_strobe,
        output running,
        output done
    );

endinterface

// File: rtl/seq_tick_timer.sv
// seq_tick_timer: tempo counter for the step sequencer.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over enable)
//   enable     : count up by one this cycle
//   gate_end   : counter is on the last cycle of the gate window
//   step_end   : counter is on the last cycle of the step
// The compare flags are combinational views of the registered counter, so
// the FSM sees them in the same cycle the counter holds that value.
module seq_tick_timer #(
    parameter int CNT_W          = 24,
    parameter int TICKS_PER_STEP = 12500000,
    parameter int GATE_TICKS     = 9375000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic gate_end,
    output logic step_end
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_TICKS - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TICKS_PER_STEP - 1);

    logic [CNT_W-1:0] tick;

    // Counter holds its value whenever the FSM neither clears nor enables
    // it, which is how a pause freezes the position inside a step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= '0;
        end else if (clear) begin
            tick <= '0;
        end else if (enable) begin
            tick <= tick + 1'b1;
        end
    end

    assign gate_end = (tick == GATE_LAST);
    assign step_end = (tick == STEP_LAST);

endmodule

// File: rtl/seq_controller.sv
// seq_controller: step sequencer playback controller.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : seq_if.slave -- play/stop_n in; step, gate, step_strobe,
//           running, done out (all outputs registered)
// Walks a step index at a fixed tempo, raising the gate for the first
// GATE_TICKS cycles of every step. Pausing freezes the position; resuming
// continues from the same tick. A stop press (falling edge of stop_n)
// returns to IDLE from anywhere.
// Build option SEQ_LOOP_EN: when defined the pattern loops forever;
// otherwise playback ends in DONE after the last step.
module seq_controller
    import seq_pkg::*;
#(
    parameter int NUM_STEPS      = DEF_NUM_STEPS,
    parameter int STEP_W         = DEF_STEP_W,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
    parameter int GATE_TICKS     = DEF_GATE_TICKS
) (
    input  logic clk,
    input  logic reset,
    seq_if.slave bus
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    seq_state_t        state, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              phase_q, phase_d;
    logic              gate_q, gate_d;
    logic              strobe_q, strobe_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              stop_prev;
    logic              stop_press;
    logic              tmr_clear, tmr_enable;
    logic              gate_end, step_end;

    seq_tick_timer #(
        .CNT_W          (CNT_W),
        .TICKS_PER_STEP (TICKS_PER_STEP),
        .GATE_TICKS     (GATE_TICKS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .gate_end (gate_end),
        .step_end (step_end)
    );

    // A press is the first low cycle after a high one, so holding the
    // button down counts only once.
    assign stop_press = stop_prev & ~bus.stop_n;

    // State and registered outputs. stop_prev resets high so a button that
    // is already held when reset releases is not seen as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step_q    <= '0;
            phase_q   <= PHASE_GATE;
            gate_q    <= 1'b0;
            strobe_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            stop_prev <= 1'b1;
        end else begin
            state     <= state_d;
            step_q    <= step_d;
            phase_q   <= phase_d;
            gate_q    <= gate_d;
            strobe_q  <= strobe_d;
            running_q <= running_d;
            done_q    <= done_d;
            stop_prev <= bus.stop_n;
        end
    end

    // Next-state and next-output logic. Outputs default low each cycle and
    // are raised by the state being entered, so the strobe can never last
    // more than one cycle. Pause checks come before tick compares so a pause
    // on a boundary cycle leaves step and tick untouched.
    always_comb begin
        state_d    = state;
        step_d     = step_q;
        phase_d    = phase_q;
        gate_d     = 1'b0;
        strobe_d   = 1'b0;
        running_d  = 1'b0;
        done_d     = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        case (state)
            IDLE: begin
                if (bus.play) begin
                    state_d   = RUN_GATE;
                    step_d    = '0;
                    tmr_clear = 1'b1;
                    gate_d    = 1'b1;
                    strobe_d  = 1'b1;
                    running_d = 1'b1;
                end
            end

            RUN_GATE: begin
                if (!bus.play) begin
                    state_d = PAUSED;
                    phase_d = PHASE_GATE;
                end else begin
                    running_d  = 1'b1;
                    tmr_enable = 1'b1;
                    if (gate_end) begin
                        state_d = RUN_REST;
                    end else begin
                        gate_d = 1'b1;
                    end
                end
            end

            RUN_REST: begin
                if (!bus.play) begin
                    state_d = PAUSED;
                    phase_d = PHASE_REST;
                end else if (step_end) begin
                    tmr_clear = 1'b1;
                    if (step_q != LAST_STEP) begin
                        state_d   = RUN_GATE;
                        step_d    = step_q + 1'b1;
                        gate_d    = 1'b1;
                        strobe_d  = 1'b1;
                        running_d = 1'b1;
                    end else begin
`ifdef SEQ_LOOP_EN
                        state_d   = RUN_GATE;
                        step_d    = '0;
                        gate_d    = 1'b1;
                        strobe_d  = 1'b1;
                        running_d = 1'b1;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    running_d  = 1'b1;
                    tmr_enable = 1'b1;
                end
            end

            PAUSED: begin
                if (bus.play) begin
                    state_d   = (phase_q == PHASE_REST) ? RUN_REST : RUN_GATE;
                    gate_d    = (phase_q == PHASE_GATE);
                    running_d = 1'b1;
                end
            end

            DONE: begin
                if (!bus.play) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                step_d    = '0;
                tmr_clear = 1'b1;
            end
        endcase

        // Stop overrides everything decided above.
        if (stop_press) begin
            state_d    = IDLE;
            step_d     = '0;
            tmr_clear  = 1'b1;
            tmr_enable = 1'b0;
            gate_d     = 1'b0;
            strobe_d   = 1'b0;
            running_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign bus.step        = step_q;
    assign bus.gate        = gate_q;
    assign bus.step_strobe = strobe_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: self-checking bench for seq_controller with a small
// pattern (4 steps, 5 ticks per step, 3 gate ticks). A behavioural model
// that tracks mode, step and position-in-step predicts the outputs after
// every clock edge; predictions go into a queue and each scenario task pops
// and compares them. Honours SEQ_LOOP_EN the same way the design does.
module tb_seq_controller;

    localparam int NS  = 4;
    localparam int SW  = 2;
    localparam int CW  = 4;
    localparam int TPS = 5;
    localparam int GT  = 3;

    typedef struct packed {
        logic [SW-1:0] step;
        logic          gate;
        logic          strobe;
        logic          running;
        logic          done;
    } obs_t;

    logic clk;
    logic reset;

    seq_if #(.STEP_W(SW)) bus ();

    seq_controller #(
        .NUM_STEPS      (NS),
        .STEP_W         (SW),
        .CNT_W          (CW),
        .TICKS_PER_STEP (TPS),
        .GATE_TICKS     (GT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t sb[$];
    obs_t exp;
    int   total;
    int   bad;

    // model: mode 0 idle, 1 running, 2 paused, 3 done
    int m_mode;
    int m_step;
    int m_tick;
    bit m_strobe;
    bit m_stop_prev;

    function automatic obs_t got();
        return {bus.step, bus.gate, bus.step_strobe, bus.running, bus.done};
    endfunction

    task automatic model_reset();
        m_mode      = 0;
        m_step      = 0;
        m_tick      = 0;
        m_strobe    = 0;
        m_stop_prev = 1;
    endtask

    task automatic model_edge(input bit p, input bit s);
        obs_t o;
        bit press;
        press       = m_stop_prev && !s;
        m_stop_prev = s;
        m_strobe    = 0;
        if (press) begin
            m_mode = 0;
            m_step = 0;
            m_tick = 0;
        end else begin
            case (m_mode)
                0: if (p) begin
                    m_mode = 1; m_step = 0; m_tick = 0; m_strobe = 1;
                end
                1: if (!p) begin
                    m_mode = 2;
                end else if (m_tick == TPS - 1) begin
                    m_tick = 0;
                    if (m_step < NS - 1) begin
                        m_step++; m_strobe = 1;
                    end else begin
`ifdef SEQ_LOOP_EN
                        m_step = 0; m_strobe = 1;
`else
                        m_mode = 3;
`endif
                    end
                end else begin
                    m_tick++;
                end
                2: if (p) m_mode = 1;
                3: if (!p) begin
                    m_mode = 0; m_step = 0;
                end
                default: m_mode = 0;
            endcase
        end
        o.step    = SW'(m_step);
        o.running = (m_mode == 1);
        o.gate    = (m_mode == 1) && (m_tick < GT);
        o.strobe  = m_strobe;
        o.done    = (m_mode == 3);
        sb.push_back(o);
    endtask

    task automatic applyStimulus(input bit p, input bit s);
        bus.play   = p;
        bus.stop_n = s;
        model_edge(p, s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.play   = 1'b0;
        bus.stop_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (got() !== obs_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_values got=%b expected=%b", got(), obs_t'(0));
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL reset_idle cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    task automatic test_walk();
        int strobes;
        int gates;
        strobes = 0;
        gates   = 0;
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL walk cyc=%0d got=%b expected=%b", i, got(), exp);
            end
            if (i < 20) begin
                strobes += int'(bus.step_strobe);
                gates   += int'(bus.gate);
            end
        end
        total++;
        if (strobes != 4) begin
            bad++;
            $display("[TB] FAIL walk_strobes got=%0d expected=4", strobes);
        end
        total++;
        if (gates != 12) begin
            bad++;
            $display("[TB] FAIL walk_gate_cycles got=%0d expected=12", gates);
        end
`ifdef SEQ_LOOP_EN
        total++;
        if (bus.step !== 2'd0 || bus.step_strobe !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL loop_wrap got step=%0d strobe=%b done=%b expected 0 1 0",
                     bus.step, bus.step_strobe, bus.done);
        end
`else
        total++;
        if (bus.done !== 1'b1 || bus.gate !== 1'b0 || bus.step !== 2'd3) begin
            bad++;
            $display("[TB] FAIL done_entry got done=%b gate=%b step=%0d expected 1 0 3",
                     bus.done, bus.gate, bus.step);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 3, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL walk_end cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
        // A looping build is paused at this point; a stop press sends both
        // builds to IDLE before the next scenario.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, i != 0);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL walk_stop cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    task automatic test_pause_gate();
        int gate_cycles;
        int step3_at;
        gate_cycles = 0;
        step3_at    = -1;
        // 12 cycles from IDLE land on step 2, tick 1
        for (int i = 0; i < 12 + 7; i++) begin
            applyStimulus(i < 12, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL pause_gate cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
        total++;
        if (bus.step !== 2'd2 || bus.gate !== 1'b0 || bus.running !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pause_hold got step=%0d gate=%b running=%b expected 2 0 0",
                     bus.step, bus.gate, bus.running);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL resume_gate cyc=%0d got=%b expected=%b", i, got(), exp);
            end
            gate_cycles += int'(bus.gate && bus.step == 2'd2);
            if (bus.step_strobe && step3_at < 0) step3_at = i;
        end
        // frozen at tick 1, so ticks 1 and 2 of the gate window remain
        total++;
        if (gate_cycles != 2) begin
            bad++;
            $display("[TB] FAIL resume_gate_len got=%0d expected=2", gate_cycles);
        end
        total++;
        if (step3_at != 4) begin
            bad++;
            $display("[TB] FAIL resume_next_step got=%0d expected=4", step3_at);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, i != 0);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL pause_stop cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    task automatic test_boundary_pause();
        // 10 cycles from IDLE reach the last tick of step 1
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i < 10, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL boundary cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
        total++;
        if (bus.step !== 2'd1 || bus.step_strobe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL boundary_hold got step=%0d strobe=%b expected 1 0",
                     bus.step, bus.step_strobe);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL boundary_resume cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    task automatic test_stop();
        int idle_cycles;
        idle_cycles = 0;
        // continue into the middle of step 3
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL stop_lead cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL stop_held cyc=%0d got=%b expected=%b", i, got(), exp);
            end
            if (i == 0) begin
                total++;
                if (bus.step !== 2'd0 || bus.gate !== 1'b0 || bus.running !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stop_effect got step=%0d gate=%b running=%b expected 0 0 0",
                             bus.step, bus.gate, bus.running);
                end
            end
            idle_cycles += int'(!bus.running);
        end
        total++;
        if (idle_cycles != 1) begin
            bad++;
            $display("[TB] FAIL stop_single got=%0d expected=1", idle_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL stop_release cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    task automatic test_async_reset();
        // walk into a gate cycle, bounded
        for (int i = 0; i < 10 && !bus.gate; i++) begin
            applyStimulus(1'b1, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL areset_lead cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
        total++;
        if (bus.gate !== 1'b1) begin
            bad++;
            $display("[TB] FAIL areset_setup got gate=%b expected 1", bus.gate);
        end
        #3;
        reset    = 1'b0;
        bus.play = 1'b0;
        #1;
        total++;
        if (got() !== obs_t'(0)) begin
            bad++;
            $display("[TB] FAIL areset_immediate got=%b expected=%b", got(), obs_t'(0));
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i >= 3, 1'b1);
            exp = sb.pop_front();
            total++;
            if (got() !== exp) begin
                bad++;
                $display("[TB] FAIL areset_after cyc=%0d got=%b expected=%b", i, got(), exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_walk();
        test_pause_gate();
        test_boundary_pause();
        test_stop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
